hvadd_axil_regs: RTL and testbench
==================================

# hvadd_axil_regs

AXI4-Lite responder that implements the vector adder's memory-mapped register file and command sequencer. It sits between the PS7 general-purpose AXI master port and the adder core. It decodes the nine-register map, launches read/write/add commands to the core over a valid/ready handshake, and reports progress through the status register. It is the slave end of the control protocol that software uses to drive the adder.

## Interface
Parameters:
- ADDR_W, 6, byte-address width of the register window (nine 32-bit registers at offsets 0x00–0x20).
- MEM_AW, 32, width of the memory address, vector address and length fields passed to the core.

Ports:
- ACLK  in  1  sole clock; all logic on its rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address. S_AXI_AWVALID in 1. S_AXI_AWREADY out 1.
- S_AXI_WDATA  in  32  write data. S_AXI_WSTRB in 4. S_AXI_WVALID in 1. S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2  write response. S_AXI_BVALID out 1. S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  ADDR_W  read address. S_AXI_ARVALID in 1. S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  32  read data. S_AXI_RRESP out 2. S_AXI_RVALID out 1. S_AXI_RREADY in 1.
- cmd_valid  out  1  command offered to the core. cmd_ready in 1, core accepts the command.
- cmd_op  out  2  1=read, 2=write, 3=add.
- cmd_addr, cmd_veca, cmd_vecb, cmd_vecr, cmd_len  out  MEM_AW each  latched operands.
- cmd_wdata  out  32  write-op data.
- core_done  in  1  one-cycle completion pulse. core_rdata in 32, valid with core_done on a read op.
- mem_busy  in  1  memory currently owned by another master.

## Operation
- Register map (byte offsets):
  - 0x00 op (RW).
  - 0x04 addr (RW).
  - 0x08 status (RO).
  - 0x0C data_read (RO).
  - 0x10 data_write (RW).
  - 0x14 veca (RW).
  - 0x18 vecb (RW).
  - 0x1C vecr (RW).
  - 0x20 vec_len (RW).
- All registers reset to 0. WSTRB byte lanes are honoured on RW registers.
- Status codes: 0 waiting, 1 done, 2 other_busy, 3 reading, 4 writing, 5 adding.
- Sequencer states and transitions:
  - IDLE (status 0). A write of op ∈ {1,2,3} stores op.
    - If mem_busy=0: go to ISSUE.
    - If mem_busy=1: go to STALL.
  - STALL (status 2). Go to ISSUE on the first cycle with mem_busy=0.
  - ISSUE (status 3/4/5 per op). Payload is copied into the cmd_* registers on entry and cmd_valid=1 is held until cmd_ready. Then go to RUN.
  - RUN (status unchanged). On core_done go to DONE. If op=1, data_read ← core_rdata in the same edge.
  - DONE (status 1). A write of op=0 goes to IDLE and status becomes 0.
- Error handling (BRESP=SLVERR, register unchanged):
  - Any op write outside its legal state: non-zero op outside IDLE, or op=0 in STALL/ISSUE/RUN.
  - Op value >3.
  - Config-register writes (0x04, 0x10–0x20) while not in IDLE/DONE.
  - Writes to status or data_read.
  - Unmapped offsets (>0x20 or not word-aligned).
- Writing op=0 while in IDLE is OKAY and a no-op.
- Unmapped reads return 0 with RRESP=SLVERR. All other responses are OKAY (2'b00).
- cmd_* payload is stable from cmd_valid rise until the next ISSUE.

## Timing
- Reset values: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, cmd_valid 0, cmd_* 0, status 0, sequencer IDLE.
- AWREADY, WREADY and ARREADY rise on the first edge after ARESET falls.
- Write channel, one outstanding transaction:
  - AW and W are accepted independently. Each ready drops once its beat is captured.
  - The register update and BVALID occur on the edge after both beats are held. AW and W handshaked at edge N give BVALID=1 after N+1.
  - BVALID is held until BREADY. Both readies re-assert on the edge after the B handshake.
- Read channel:
  - ARREADY drops after the handshake. RVALID and RDATA are registered on the next edge and held until RREADY. ARREADY returns on the edge after the R handshake.
  - RDATA reflects register contents before any update occurring in the same edge.
- Command handshake: cmd_valid rises the edge after the op write commits (or after mem_busy falls in STALL). It falls on the edge where cmd_valid & cmd_ready.
- A core_done arriving in the same cycle as the cmd handshake is ignored. Only core_done in RUN counts.
- Read and write channels operate concurrently. A simultaneous read of status returns the pre-edge value.
- ARESET mid-operation clears everything asynchronously, including an in-flight cmd_valid. Pending AXI responses are discarded.

## Test plan
- Reset check: ARESET high with random inputs → all outputs 0; one edge after release, AWREADY=WREADY=ARREADY=1.
- Write sequence: write 0x04=8, 0x10=32, 0x00=2 → cmd_valid with cmd_op=2, cmd_addr=8, cmd_wdata=32, status=4. Then cmd_ready, then core_done → status=1. Op=0 → status=0.
- Read sequence: op=1 with core_rdata=48 at core_done → data_read (0x0C) reads 48.
- Add with mem_busy=1 for 5 cycles, veca=4, vecb=8, vecr=16, len=4 → status=2 for 5 cycles, then 5. cmd_op=3 with matching payload.
- Error paths: op=3 while RUN → SLVERR, no second cmd_valid. Write 0x08 → SLVERR. Read 0x24 → RDATA=0, RRESP=SLVERR. WSTRB=4'b0001 to veca=0xFFFF_FFFF over 0x12345678 → reads 0x123456FF.
- Back-pressure: BREADY/RREADY held low 10 cycles → BVALID/RVALID and data stable, no new AW/AR accepted. ARESET asserted during RUN → cmd_valid=0 and status=0 immediately.

Source files
------------

// File: rtl/hvadd_axil_regs.sv
// AXI4-Lite register file and command sequencer for the vector adder core.
// Decodes the nine-word register map and hands read/write/add commands to the core.
module hvadd_axil_regs #(
  parameter int ADDR_W = 6,
  parameter int MEM_AW = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [MEM_AW-1:0] cmd_addr,
  output logic [MEM_AW-1:0] cmd_veca,
  output logic [MEM_AW-1:0] cmd_vecb,
  output logic [MEM_AW-1:0] cmd_vecr,
  output logic [MEM_AW-1:0] cmd_len,
  output logic [31:0]       cmd_wdata,
  input  logic              core_done,
  input  logic [31:0]       core_rdata,
  input  logic              mem_busy
);

  localparam logic [ADDR_W-1:0] A_OP    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_ADDR  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_DRD   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_DWR   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_VECA  = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_VECB  = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] A_VECR  = ADDR_W'(8'h1C);
  localparam logic [ADDR_W-1:0] A_LEN   = ADDR_W'(8'h20);
  localparam logic [1:0]        OKAY    = 2'b00;
  localparam logic [1:0]        SLVERR  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_STALL, S_ISSUE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic              awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              arready_q, ar_held_q, rvalid_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] araddr_q;

  logic [1:0]        op_q;
  logic [31:0]       addr_q, dwrite_q, veca_q, vecb_q, vecr_q, len_q, dread_q;
  logic              cmd_valid_q;
  logic [1:0]        cmd_op_q;
  logic [MEM_AW-1:0] cmd_addr_q, cmd_veca_q, cmd_vecb_q, cmd_vecr_q, cmd_len_q;
  logic [31:0]       cmd_wdata_q;

  logic [2:0]        status;
  logic              cfg_open;
  logic              wr_commit, wr_ok, wr_fire, op_start, op_clear;
  logic [31:0]       wr_old, wr_val, rd_val;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= A_LEN);
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] reg_rd(input logic [ADDR_W-1:0] a);
    case (a)
      A_OP:    return {30'd0, op_q};
      A_ADDR:  return addr_q;
      A_STAT:  return {29'd0, status};
      A_DRD:   return dread_q;
      A_DWR:   return dwrite_q;
      A_VECA:  return veca_q;
      A_VECB:  return vecb_q;
      A_VECR:  return vecr_q;
      A_LEN:   return len_q;
      default: return 32'd0;
    endcase
  endfunction

  assign wr_commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_fire   = wr_commit & wr_ok;

  // Write legality: op writes depend on sequencer state, config only while quiescent
  always_comb begin
    wr_ok    = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    wr_old   = reg_rd(awaddr_q);
    wr_val   = merge_strb(wr_old, wdata_q, wstrb_q);
    case (awaddr_q)
      A_OP: begin
        if (wr_val == 32'd0) begin
          wr_ok    = (state_q == S_IDLE) || (state_q == S_DONE);
          op_clear = (state_q == S_DONE);
        end else if (wr_val <= 32'd3 && state_q == S_IDLE) begin
          wr_ok    = 1'b1;
          op_start = 1'b1;
        end
      end
      A_ADDR, A_DWR, A_VECA, A_VECB, A_VECR, A_LEN: wr_ok = cfg_open;
      default: wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (awready_q) begin
        if (S_AXI_AWVALID) begin
          awready_q <= 1'b0;
          aw_held_q <= 1'b1;
          awaddr_q  <= S_AXI_AWADDR;
        end
      end else if (!aw_held_q && !bvalid_q) begin
        awready_q <= 1'b1;
      end
      if (wready_q) begin
        if (S_AXI_WVALID) begin
          wready_q <= 1'b0;
          w_held_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
      end else if (!w_held_q && !bvalid_q) begin
        wready_q <= 1'b1;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  always_comb rd_val = reg_rd(araddr_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      ar_held_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      araddr_q  <= '0;
    end else begin
      if (arready_q) begin
        if (S_AXI_ARVALID) begin
          arready_q <= 1'b0;
          ar_held_q <= 1'b1;
          araddr_q  <= S_AXI_ARADDR;
        end
      end else if (!ar_held_q && !rvalid_q) begin
        arready_q <= 1'b1;
      end
      if (ar_held_q && !rvalid_q) begin
        rvalid_q  <= 1'b1;
        ar_held_q <= 1'b0;
        rdata_q   <= is_mapped(araddr_q) ? rd_val : 32'd0;
        rresp_q   <= is_mapped(araddr_q) ? OKAY : SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      op_q     <= '0;
      addr_q   <= '0;
      dwrite_q <= '0;
      veca_q   <= '0;
      vecb_q   <= '0;
      vecr_q   <= '0;
      len_q    <= '0;
      dread_q  <= '0;
    end else begin
      if (wr_fire) begin
        case (awaddr_q)
          A_OP:    op_q     <= wr_val[1:0];
          A_ADDR:  addr_q   <= wr_val;
          A_DWR:   dwrite_q <= wr_val;
          A_VECA:  veca_q   <= wr_val;
          A_VECB:  vecb_q   <= wr_val;
          A_VECR:  vecr_q   <= wr_val;
          A_LEN:   len_q    <= wr_val;
          default: ;
        endcase
      end
      if (state_q == S_RUN && core_done && op_q == 2'd1) dread_q <= core_rdata;
    end
  end

  // Payload is latched on the first ISSUE cycle and held until the next ISSUE
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_veca_q  <= '0;
      cmd_vecb_q  <= '0;
      cmd_vecr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_wdata_q <= '0;
    end else if (state_q == S_ISSUE) begin
      if (!cmd_valid_q) begin
        cmd_valid_q <= 1'b1;
        cmd_op_q    <= op_q;
        cmd_addr_q  <= MEM_AW'(addr_q);
        cmd_veca_q  <= MEM_AW'(veca_q);
        cmd_vecb_q  <= MEM_AW'(vecb_q);
        cmd_vecr_q  <= MEM_AW'(vecr_q);
        cmd_len_q   <= MEM_AW'(len_q);
        cmd_wdata_q <= dwrite_q;
      end else if (cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wr_fire && op_start) state_d = mem_busy ? S_STALL : S_ISSUE;
      S_STALL: if (!mem_busy) state_d = S_ISSUE;
      S_ISSUE: if (cmd_valid_q && cmd_ready) state_d = S_RUN;
      S_RUN:   if (core_done) state_d = S_DONE;
      S_DONE:  if (wr_fire && op_clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status   = 3'd0;
    cfg_open = 1'b0;
    case (state_q)
      S_IDLE:         cfg_open = 1'b1;
      S_STALL:        status   = 3'd2;
      S_ISSUE, S_RUN: status   = {1'b0, op_q} + 3'd2;
      S_DONE: begin
        status   = 3'd1;
        cfg_open = 1'b1;
      end
      default:        status   = 3'd0;
    endcase
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_op        = cmd_op_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_veca      = cmd_veca_q;
  assign cmd_vecb      = cmd_vecb_q;
  assign cmd_vecr      = cmd_vecr_q;
  assign cmd_len       = cmd_len_q;
  assign cmd_wdata     = cmd_wdata_q;

endmodule

// File: tb/tb_hvadd_axil_regs.sv
// Directed bench for hvadd_axil_regs: register map, sequencer flow, error responses,
// back-pressure and asynchronous reset.
module tb_hvadd_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_veca, cmd_vecb, cmd_vecr, cmd_len, cmd_wdata;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        mem_busy;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [1:0]  resp;
  logic [31:0] rd;
  logic [31:0] rnd;

  hvadd_axil_regs #(.ADDR_W(6), .MEM_AW(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_veca(cmd_veca), .cmd_vecb(cmd_vecb), .cmd_vecr(cmd_vecr), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .core_done(core_done), .core_rdata(core_rdata), .mem_busy(mem_busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bhold, output logic [1:0] r);
    bit aw_done, w_done, a_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0; r = 2'b11;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge ACLK);
      a_hs = S_AXI_AWVALID & S_AXI_AWREADY;
      w_hs = S_AXI_WVALID & S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (a_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs) begin S_AXI_WVALID = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      chk("wr_accept_timeout", 0, 1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (!S_AXI_BVALID) begin chk("bvalid_timeout", 0, 1); return; end
    if (bhold > 0) begin
      S_AXI_AWADDR = 6'h10; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      for (int i = 0; i < bhold; i++) begin
        @(posedge ACLK); #1;
        chk("b_hold_vld_noaccept", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
    r = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input int rhold,
                          output logic [31:0] d, output logic [1:0] r);
    bit done, hs;
    int n;
    done = 0; n = 0; d = 32'hDEAD_BEEF; r = 2'b11;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!done && n < 20) begin
      @(negedge ACLK);
      hs = S_AXI_ARVALID & S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin S_AXI_ARVALID = 1'b0; done = 1; end
      n++;
    end
    if (!done) begin chk("rd_accept_timeout", 0, 1); S_AXI_ARVALID = 1'b0; return; end
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (!S_AXI_RVALID) begin chk("rvalid_timeout", 0, 1); return; end
    if (rhold > 0) begin
      S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < rhold; i++) begin
        @(posedge ACLK); #1;
        chk("r_hold_vld_noaccept", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b10);
      end
      S_AXI_ARVALID = 1'b0;
    end
    d = S_AXI_RDATA;
    r = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_cmd();
    int n;
    n = 0;
    while (!cmd_valid && n < 10) begin @(posedge ACLK); #1; n++; end
    chk("cmd_valid_rise", cmd_valid, 1);
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    @(posedge ACLK); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic [31:0] rdat);
    core_rdata = rdat; core_done = 1'b1;
    @(posedge ACLK); #1;
    core_done = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    cmd_ready = 0; core_done = 0; core_rdata = '0; mem_busy = 0;

    // Reset with random activity on the inputs
    repeat (4) begin
      @(posedge ACLK); #1;
      rnd = $urandom;
      S_AXI_AWADDR = rnd[5:0]; S_AXI_ARADDR = rnd[11:6]; S_AXI_WSTRB = rnd[15:12];
      S_AXI_AWVALID = rnd[16]; S_AXI_WVALID = rnd[17]; S_AXI_BREADY = rnd[18];
      S_AXI_ARVALID = rnd[19]; S_AXI_RREADY = rnd[20]; cmd_ready = rnd[21];
      core_done = rnd[22]; mem_busy = rnd[23];
      S_AXI_WDATA = $urandom; core_rdata = $urandom;
    end
    chk("rst_ctrl_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                             S_AXI_RVALID, cmd_valid, S_AXI_BRESP, S_AXI_RRESP}, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_payload", {cmd_op, cmd_addr | cmd_veca | cmd_vecb | cmd_vecr | cmd_len | cmd_wdata}, 0);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    cmd_ready = 0; core_done = 0; mem_busy = 0;
    @(negedge ACLK); ARESET = 1'b0;
    #1 chk("rdy_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(posedge ACLK); #1;
    chk("rdy_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Write operation
    axi_write(6'h04, 32'd8, 4'hF, 0, resp);  chk("wr_addr_resp", resp, 2'b00);
    axi_write(6'h10, 32'd32, 4'hF, 0, resp); chk("wr_dwr_resp", resp, 2'b00);
    axi_write(6'h00, 32'd2, 4'hF, 0, resp);  chk("wr_op2_resp", resp, 2'b00);
    wait_cmd();
    chk("wr_cmd_op", cmd_op, 2);
    chk("wr_cmd_addr", cmd_addr, 8);
    chk("wr_cmd_wdata", cmd_wdata, 32);
    axi_read(6'h08, 0, rd, resp); chk("status_writing", rd, 4);
    chk("cmd_held_no_ready", cmd_valid, 1);
    pulse_ready();
    chk("cmd_drop_on_ready", cmd_valid, 0);
    axi_read(6'h08, 0, rd, resp); chk("status_run_writing", rd, 4);
    pulse_done(32'h0);
    axi_read(6'h08, 0, rd, resp); chk("status_done", rd, 1);
    axi_write(6'h00, 32'd0, 4'hF, 0, resp); chk("op0_done_resp", resp, 2'b00);
    axi_read(6'h08, 0, rd, resp); chk("status_idle", rd, 0);

    // Read operation
    axi_write(6'h00, 32'd1, 4'hF, 0, resp); chk("rd_op1_resp", resp, 2'b00);
    wait_cmd();
    chk("rd_cmd_op", cmd_op, 1);
    axi_read(6'h08, 0, rd, resp); chk("status_reading", rd, 3);
    pulse_ready();
    pulse_done(32'd48);
    axi_read(6'h0C, 0, rd, resp); chk("data_read_48", {resp, rd}, {2'b00, 32'd48});
    axi_write(6'h00, 32'd0, 4'hF, 0, resp);

    // Add operation stalled behind another bus master
    mem_busy = 1'b1;
    axi_write(6'h14, 32'd4, 4'hF, 0, resp);
    axi_write(6'h18, 32'd8, 4'hF, 0, resp);
    axi_write(6'h1C, 32'd16, 4'hF, 0, resp);
    axi_write(6'h20, 32'd4, 4'hF, 0, resp); chk("wr_len_resp", resp, 2'b00);
    axi_write(6'h00, 32'd3, 4'hF, 0, resp); chk("add_op3_resp", resp, 2'b00);
    axi_read(6'h08, 0, rd, resp); chk("status_stall", rd, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      chk("stall_no_cmd", cmd_valid, 0);
    end
    axi_read(6'h08, 0, rd, resp); chk("status_stall_late", rd, 2);
    mem_busy = 1'b0;
    wait_cmd();
    chk("add_cmd_op", cmd_op, 3);
    chk("add_cmd_vecs", {cmd_veca, cmd_vecb, cmd_vecr, cmd_len},
        {32'd4, 32'd8, 32'd16, 32'd4});
    axi_read(6'h08, 0, rd, resp); chk("status_adding", rd, 5);
    cmd_ready = 1'b1; core_done = 1'b1;
    @(posedge ACLK); #1;
    cmd_ready = 1'b0; core_done = 1'b0;
    chk("add_cmd_drop", cmd_valid, 0);
    axi_read(6'h08, 0, rd, resp); chk("done_with_hs_ignored", rd, 5);

    // Illegal accesses while running and after completion
    axi_write(6'h00, 32'd3, 4'hF, 0, resp); chk("op_in_run_slverr", resp, 2'b10);
    repeat (3) @(posedge ACLK); #1;
    chk("no_second_cmd", cmd_valid, 0);
    axi_read(6'h00, 0, rd, resp); chk("op_unchanged", rd, 3);
    axi_write(6'h00, 32'd0, 4'hF, 0, resp); chk("op0_in_run_slverr", resp, 2'b10);
    axi_write(6'h04, 32'h99, 4'hF, 0, resp); chk("cfg_in_run_slverr", resp, 2'b10);
    pulse_done(32'h0);
    axi_read(6'h08, 0, rd, resp); chk("status_done_add", rd, 1);
    axi_write(6'h00, 32'd2, 4'hF, 0, resp); chk("op_in_done_slverr", resp, 2'b10);
    axi_write(6'h08, 32'd7, 4'hF, 0, resp); chk("wr_status_slverr", resp, 2'b10);
    axi_write(6'h0C, 32'd7, 4'hF, 0, resp); chk("wr_dread_slverr", resp, 2'b10);
    axi_read(6'h24, 0, rd, resp); chk("rd_unmapped", {resp, rd}, {2'b10, 32'd0});
    axi_read(6'h04, 0, rd, resp); chk("addr_unchanged", {resp, rd}, {2'b00, 32'd8});
    axi_write(6'h00, 32'd0, 4'hF, 0, resp); chk("op0_clear_resp", resp, 2'b00);
    axi_read(6'h08, 0, rd, resp); chk("status_cleared", rd, 0);
    axi_write(6'h00, 32'd0, 4'hF, 0, resp); chk("op0_idle_okay", resp, 2'b00);
    axi_write(6'h00, 32'd5, 4'hF, 0, resp); chk("op5_slverr", resp, 2'b10);
    axi_read(6'h00, 0, rd, resp); chk("op_after_bad", rd, 0);
    axi_write(6'h06, 32'd1, 4'hF, 0, resp); chk("unaligned_slverr", resp, 2'b10);

    // Byte-lane strobes
    axi_write(6'h14, 32'h1234_5678, 4'hF, 0, resp);
    axi_write(6'h14, 32'hFFFF_FFFF, 4'b0001, 0, resp); chk("strb_resp", resp, 2'b00);
    axi_read(6'h14, 0, rd, resp); chk("strb_merge", rd, 32'h1234_56FF);
    axi_write(6'h18, 32'hFFFF_FFFF, 4'b1010, 0, resp);
    axi_read(6'h18, 0, rd, resp); chk("strb_merge_hi", rd, 32'hFF00_FF08);

    // Back-pressure on both response channels
    axi_write(6'h1C, 32'h0000_A5A5, 4'hF, 10, resp); chk("bp_bresp", resp, 2'b00);
    axi_read(6'h1C, 10, rd, resp); chk("bp_rdata", {resp, rd}, {2'b00, 32'h0000_A5A5});

    // Asynchronous reset while a command is being offered
    axi_write(6'h00, 32'd2, 4'hF, 0, resp);
    wait_cmd();
    #2 ARESET = 1'b1;
    #1 chk("rst_mid_ctrl", {cmd_valid, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 4'b0000);
    chk("rst_mid_payload", {cmd_op, cmd_addr}, 0);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    axi_read(6'h08, 0, rd, resp); chk("rst_mid_status", rd, 0);
    axi_read(6'h04, 0, rd, resp); chk("rst_mid_addr", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
